// File: rtl/imm_ext_pkg.sv
// Shared encodings for the immediate extender: operand modes and skid-buffer states.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    IMM_SEXT  = 2'b00,
    IMM_ZEXT  = 2'b01,
    IMM_UPPER = 2'b10,
    IMM_RSVD  = 2'b11
  } imm_mode_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } buf_state_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extension (sign / zero / upper). Upper mode is only built
// when IMM_EXT_UPPER_EN is defined; otherwise mode 10 reports as reserved.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 17,
  parameter int unsigned OUT_W = 32
) (
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic [OUT_W-1:0] ext_data,
  output logic             ext_err
);

  logic [OUT_W-1:0] sext_v;
  logic [OUT_W-1:0] zext_v;
`ifdef IMM_EXT_UPPER_EN
  logic [OUT_W-1:0] upper_v;
`endif

  generate
    if (IN_W < 1 || OUT_W < IN_W) begin : g_bad_width
      $error("imm_ext_core: requires IN_W >= 1 and OUT_W >= IN_W");
    end else if (OUT_W == IN_W) begin : g_pass
      assign sext_v = in_data;
      assign zext_v = in_data;
`ifdef IMM_EXT_UPPER_EN
      assign upper_v = in_data;
`endif
    end else begin : g_ext
      assign sext_v = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
      assign zext_v = {{(OUT_W-IN_W){1'b0}}, in_data};
`ifdef IMM_EXT_UPPER_EN
      assign upper_v = {in_data, {(OUT_W-IN_W){1'b0}}};
`endif
    end
  endgenerate

  // Unsupported modes still produce the sign-extended value so the operand is defined.
  always_comb begin
    ext_data = sext_v;
    ext_err  = 1'b0;
    case (imm_mode_t'(in_mode))
      IMM_SEXT:  ext_data = sext_v;
      IMM_ZEXT:  ext_data = zext_v;
`ifdef IMM_EXT_UPPER_EN
      IMM_UPPER: ext_data = upper_v;
`endif
      default:   ext_err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender with valid/ready on both sides and a 2-entry skid buffer.
// Optional upper-immediate mode via IMM_EXT_UPPER_EN.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 17,
  parameter int unsigned OUT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  buf_state_t       state, state_nxt;
  logic             load_main, load_skid, skid_to_main;
  logic             in_fire, out_fire;
  logic [OUT_W-1:0] ext_data;
  logic             ext_err;
  logic [OUT_W-1:0] main_data, skid_data;
  logic             main_err, skid_err;

  imm_ext_core #(
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) u_core (
    .in_data (in_data),
    .in_mode (in_mode),
    .ext_data(ext_data),
    .ext_err (ext_err)
  );

  // Handshake outputs come from state alone, keeping both directions register-isolated.
  assign in_ready  = (state != ST_TWO);
  assign out_valid = (state != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = main_data;
  assign out_err   = main_err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          load_main = 1'b1;
          state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_nxt = ST_TWO;
        end else if (out_fire) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_fire) begin
          skid_to_main = 1'b1;
          state_nxt    = ST_ONE;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      main_data <= '0;
      main_err  <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      if (load_main) begin
        main_data <= ext_data;
        main_err  <= ext_err;
      end else if (skid_to_main) begin
        main_data <= skid_data;
        main_err  <= skid_err;
      end
      if (load_skid) begin
        skid_data <= ext_data;
        skid_err  <= ext_err;
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe (17->32 plus a 1->8 instance).
// Expectations for mode 10 follow IMM_EXT_UPPER_EN.
module tb_imm_extend_pipe;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [16:0] in_data = '0;
  logic [1:0]  in_mode = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_err;

  logic        n_in_valid = 1'b0;
  logic        n_in_ready;
  logic [0:0]  n_in_data = '0;
  logic [1:0]  n_in_mode = 2'b00;
  logic        n_out_valid;
  logic        n_out_ready = 1'b1;
  logic [7:0]  n_out_data;
  logic        n_out_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  imm_extend_pipe #(.IN_W(17), .OUT_W(32)) u_dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  imm_extend_pipe #(.IN_W(1), .OUT_W(8)) u_dut_narrow (
    .clock(clock), .reset(reset),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data), .in_mode(n_in_mode),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data), .out_err(n_out_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [16:0] d);
    in_valid = v;
    in_mode  = m;
    in_data  = d;
  endtask

  initial begin
    logic [16:0] sd;
    logic [31:0] se;

    // Reset state
    #1 reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);
    check("rst_in_ready", in_ready, 1);
    drive(1'b1, 2'b00, 17'h10000);
    step();
    check("rst_no_accept", out_valid, 0);
    reset = 1'b1;

    // Single-cycle latency, each mode
    out_ready  = 1'b1;
    n_in_valid = 1'b1;
    n_in_data  = 1'b1;
    n_in_mode  = 2'b00;
    drive(1'b1, 2'b00, 17'h10000);
    step();
    check("sext_valid", out_valid, 1);
    check("sext_data", out_data, 32'hFFFF0000);
    check("sext_err", out_err, 0);
    check("w1_sext_valid", n_out_valid, 1);
    check("w1_sext_data", n_out_data, 8'hFF);
    n_in_valid = 1'b0;
    drive(1'b1, 2'b01, 17'h1ABCD);
    step();
    check("zext_data", out_data, 32'h0001ABCD);
    check("zext_err", out_err, 0);
    drive(1'b1, 2'b10, 17'h00001);
    step();
`ifdef IMM_EXT_UPPER_EN
    check("upper_data", out_data, 32'h00008000);
    check("upper_err", out_err, 0);
`else
    check("upper_off_data", out_data, 32'h00000001);
    check("upper_off_err", out_err, 1);
`endif
    drive(1'b1, 2'b11, 17'h10000);
    step();
    check("rsvd_data", out_data, 32'hFFFF0000);
    check("rsvd_err", out_err, 1);
    drive(1'b0, 2'b00, 17'h0);
    step();
    check("drain_valid", out_valid, 0);

    // Backpressure: A, B fill the buffer, C waits
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 17'd1);
    step();
    check("bp_ready_one", in_ready, 1);
    drive(1'b1, 2'b01, 17'd2);
    step();
    check("bp_ready_two", in_ready, 0);
    drive(1'b1, 2'b01, 17'd3);
    step();
    step();
    check("bp_hold_ready", in_ready, 0);
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_data", out_data, 32'd1);
    out_ready = 1'b1;
    step();
    check("bp_b_data", out_data, 32'd2);
    check("bp_ready_back", in_ready, 1);
    step();
    check("bp_c_data", out_data, 32'd3);
    check("bp_c_valid", out_valid, 1);
    drive(1'b0, 2'b00, 17'h0);
    step();
    check("bp_empty", out_valid, 0);

    // Streaming: 8 back-to-back, mixed signs
    for (int i = 0; i < 8; i++) begin
      sd = (i % 2 == 1) ? (17'h1FF00 | 17'(i)) : (17'h00100 + 17'(i));
      se = (i % 2 == 1) ? (32'hFFFFFF00 | 32'(i)) : (32'h00000100 + 32'(i));
      drive(1'b1, 2'b00, sd);
      step();
      check($sformatf("stream_valid_%0d", i), out_valid, 1);
      check($sformatf("stream_data_%0d", i), out_data, se);
    end
    drive(1'b0, 2'b00, 17'h0);
    step();
    check("stream_end", out_valid, 0);

    // Asynchronous reset while full
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 17'd5);
    step();
    drive(1'b1, 2'b01, 17'd6);
    step();
    check("ar_full", in_ready, 0);
    drive(1'b0, 2'b00, 17'h0);
    #2 reset = 1'b0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_data", out_data, 0);
    check("ar_ready", in_ready, 1);
    #1 reset = 1'b1;
    step();
    out_ready = 1'b1;
    drive(1'b1, 2'b01, 17'h00042);
    step();
    check("ar_post_valid", out_valid, 1);
    check("ar_post_data", out_data, 32'h00000042);
    drive(1'b0, 2'b00, 17'h0);
    step();
    check("ar_post_empty", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
